// File: rtl/seg7_decode_capture.sv
// Decodes active-low 7-segment glyphs back to hex digits. Each pattern must be
// stable for STABLE_CYCLES strobed samples; NUM_DIGITS digits form one output word.
module seg7_decode_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [6:0]              iSEG,
  input  logic                    iSTB,
  input  logic                    iREADY,
  output logic [4*NUM_DIGITS-1:0] oDIG,
  output logic                    oVALID,
  output logic                    oERR
);

  typedef enum logic [1:0] {IDLE, FILTER, RELEASE, OUT} state_t;

  localparam int         W      = 4 * NUM_DIGITS;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam logic [3:0] FULL   = 4'(NUM_DIGITS);

  state_t     state;
  logic [6:0] held;
  logic [3:0] cnt;
  logic [3:0] dcnt;
  logic [3:0] cand_cnt;
  logic       accept;
  logic [4:0] dec;

  // Returns {legal, digit}; 0000000 is the all-segments-lit 8.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // A fresh or changed pattern restarts the run at 1; a repeat extends it.
  always_comb begin
    cand_cnt = 4'd1;
    if (state == FILTER && iSEG == held)
      cand_cnt = cnt + 4'd1;
    accept = iSTB && (state == IDLE || state == FILTER) && (cand_cnt == STABLE);
    dec    = decode(iSEG);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      oDIG   <= '0;
      oVALID <= 1'b0;
      oERR   <= 1'b0;
      held   <= '0;
      cnt    <= '0;
      dcnt   <= '0;
    end else begin
      oERR <= 1'b0;
      case (state)
        IDLE, FILTER: begin
          if (!iSTB) begin
            state <= IDLE;
          end else begin
            held <= iSEG;
            cnt  <= cand_cnt;
            if (accept) begin
              state <= RELEASE;
              if (dec[4]) begin
                oDIG <= (oDIG << 4) | W'(dec[3:0]);
                dcnt <= dcnt + 4'd1;
              end else begin
                oERR <= 1'b1;
                oDIG <= '0;
                dcnt <= '0;
              end
            end else begin
              state <= FILTER;
            end
          end
        end
        RELEASE: begin
          // One capture per strobe: hold here until the strobe drops.
          if (!iSTB) begin
            if (dcnt == FULL) begin
              state  <= OUT;
              oVALID <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OUT: begin
          if (iREADY) begin
            oVALID <= 1'b0;
            dcnt   <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg7_decode_capture.md
Name: seg7_decode_capture

Overview:
- Reverse direction of the board's hex-to-7-segment encoding: takes active-low 7-segment patterns and decodes them back to 4-bit hex digits.
- Glitch-filters each pattern and assembles NUM_DIGITS digits into one word.
- Hands the word to a downstream consumer with a valid/ready handshake.
- Used to read back display buses (e.g. a scanned panel or a loopback from the HEX drivers) into the SoC fabric.

Parameters:
- NUM_DIGITS, 4, number of digits per output word (1..8).
- STABLE_CYCLES, 4, consecutive identical strobed samples required before a pattern is accepted (1..15).

Ports:
- iCLK  input  1  system clock; all logic on rising edge.
- iRST  input  1  synchronous reset, active-high.
- iSEG  input  7  active-low segment pattern; bit0=a(top), 1=b(rt), 2=c(rb), 3=d(bottom), 4=e(lb), 5=f(lt), 6=g(middle).
- iSTB  input  1  pattern-present strobe; high while iSEG is driven with a digit.
- iREADY  input  1  consumer accepts oDIG when high with oVALID.
- oDIG  output  4*NUM_DIGITS  assembled word; first-captured digit in the most significant nibble.
- oVALID  output  1  oDIG holds a complete word.
- oERR  output  1  one-cycle pulse: an accepted pattern was not a legal hex glyph.

Behaviour:
- Reset: on a rising iCLK with iRST=1, the following are all cleared on that edge, and iRST takes priority over every other event:
  - state goes to IDLE;
  - oDIG=0, oVALID=0, oERR=0;
  - digit count, stable counter and held pattern are cleared.
  - A reset mid-word discards the partial word.
- Decode table (iSEG -> digit):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7.
  - 0010000->8, 0000000->8, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F.
  - Correction: 0000000 decodes to 8 only; 0010000 decodes to 9.
  - Every other pattern is illegal.
- State machine IDLE / FILTER / RELEASE / OUT:
  - IDLE:
    - iSTB=1: load held pattern from iSEG, stable count=1, go to FILTER.
    - If STABLE_CYCLES=1, perform the accept action below immediately.
  - FILTER:
    - iSTB=0: return to IDLE, no side effects.
    - iSEG differs from held pattern: reload held pattern, count=1.
    - iSEG matches: count+1.
    - On the edge where count reaches STABLE_CYCLES, accept, then go to RELEASE.
  - Accept, legal pattern: oDIG shifts left 4 and the new digit enters bits[3:0]; digit count +1.
  - Accept, illegal pattern: oERR=1 for exactly the next cycle; oDIG=0; digit count=0.
  - RELEASE:
    - Waits for iSTB=0; a strobe held high never double-captures.
    - On the edge sampling iSTB=0: if digit count == NUM_DIGITS go to OUT with oVALID=1 from the next cycle, else go to IDLE.
  - OUT:
    - oVALID=1 and oDIG stable; iSTB/iSEG are ignored and patterns are dropped.
    - On the edge with iREADY=1: oVALID=0 from the next cycle, digit count=0, go to IDLE.
    - oDIG retains its value until the next accept.
- Latency: with STABLE_CYCLES=N, a digit is accepted on the N-th consecutive strobed matching edge. Minimum spacing between digits is N+1 cycles.
- oERR never coincides with oVALID.

Test Plan:
1. Strobe patterns for 1,2,3,4 for 4 cycles each, with 1 idle cycle between, iREADY=1 -> oDIG=16'h1234, oVALID high exactly 1 cycle, starting 1 cycle after the final strobe drop.
2. Glitch filter: 0000000 (8) for 2 cycles, then 0010000 (9) for 4 cycles in one strobe -> only digit 9 accepted, digit count +1.
3. Illegal pattern: 1111111 held 4 strobed cycles after digits A,b -> oERR pulses 1 cycle, oDIG=0. Then C,d,E,F -> oDIG=16'hCDEF.
4. Backpressure: complete word 16'h9A0F with iREADY=0 for 10 cycles -> oVALID stays high, oDIG constant, intervening strobes dropped. Raise iREADY -> oVALID low next cycle.
5. Short strobe: iSTB high 3 cycles (STABLE_CYCLES=4) -> no accept, digit count unchanged, no oERR.
6. Reset mid-word: iRST pulsed after 2 digits, then 4 digits 5,6,7,8 -> oDIG=16'h5678; no stale nibbles.
